// File: rtl/zombie_round_ctrl_pkg.sv
// Shared types and helpers for the zombie round controller.
//   state_e      : round FSM states
//   HOLE_*       : hole index encoding produced by the random stage (0 = no hole)
//   hole_onehot  : hole index -> one-hot LED/button mask
//   max_u        : larger of two unsigned ints, used for timer sizing
package zombie_round_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StShow = 3'd3,
    StGap  = 3'd4,
    StOver = 3'd5
  } state_e;

  localparam logic [1:0] HOLE_NONE = 2'd0;
  localparam logic [1:0] HOLE_1    = 2'd1;
  localparam logic [1:0] HOLE_2    = 2'd2;
  localparam logic [1:0] HOLE_3    = 2'd3;

  function automatic logic [2:0] hole_onehot(input logic [1:0] hole);
    logic [2:0] oh;
    case (hole)
      HOLE_1:  oh = 3'b001;
      HOLE_2:  oh = 3'b010;
      HOLE_3:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/zombie_round_ctrl_edge_detect.sv
// Rising-edge detector for a bundle of level inputs.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (clears the history register)
//   sig_i  : level inputs, already synchronous/debounced
//   rise_o : high in the cycle an input is high and was low the previous cycle
module zombie_round_ctrl_edge_detect #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] sig_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] prev_q;
  logic [Width-1:0] prev_d;

  always_comb begin
    prev_d = sig_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // A held level produces exactly one event.
  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/zombie_round_ctrl.sv
// Whack-a-zombie round controller.
// Requests a hole from the random stage, shows a zombie there, times the punch
// window, scores hits and takes lives on misses/timeouts, and ends the game at
// zero lives.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : level; rising edge starts a game from idle or game over
//   btn[2:0]     : punch buttons, btn[i] is hole i+1
//   rand_num     : hole index from random stage, valid one cycle after gen_random
//   gen_random   : one-cycle request pulse to the random stage
//   zombie_led   : one-hot hole display, zero when nothing is shown
//   score        : hits this game (saturating)
//   lives_left   : remaining lives
//   hit_pulse    : one-cycle pulse on a correct punch
//   miss_pulse   : one-cycle pulse on a wrong punch or timeout
//   game_over    : high while the game is over
module zombie_round_ctrl
  import zombie_round_ctrl_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 62_500_000,
  parameter int unsigned GAP_CYCLES  = 15_625_000,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         btn,
  input  logic [1:0]         rand_num,
  output logic               gen_random,
  output logic [2:0]         zombie_led,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives_left,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over
);

  localparam int unsigned TimerMax = max_u(SHOW_CYCLES, GAP_CYCLES);
  localparam int unsigned TimerW   = $clog2(TimerMax);

  localparam logic [TimerW-1:0] ShowLoad  = TimerW'(SHOW_CYCLES - 1);
  localparam logic [TimerW-1:0] GapLoad   = TimerW'(GAP_CYCLES - 1);
  localparam logic [2:0]        LivesInit = 3'(LIVES);

  // Input edge detection
  logic [2:0] btn_rise;
  logic       start_rise;

  zombie_round_ctrl_edge_detect #(
    .Width (3)
  ) u_btn_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (btn),
    .rise_o (btn_rise)
  );

  zombie_round_ctrl_edge_detect #(
    .Width (1)
  ) u_start_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (start),
    .rise_o (start_rise)
  );

  // State and registered outputs
  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [1:0]         hole_q, hole_d;
  logic               gen_random_q, gen_random_d;
  logic [2:0]         zombie_led_q, zombie_led_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               game_over_q, game_over_d;

  logic [2:0] hole_mask;
  logic       punch_ok;
  logic       punch_bad;
  logic [2:0] lives_dec;

  always_comb begin
    hole_mask = hole_onehot(hole_q);
    punch_ok  = |(btn_rise & hole_mask);
    punch_bad = |(btn_rise & ~hole_mask);
    lives_dec = lives_q - 3'd1;
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hole_d       = hole_q;
    gen_random_d = 1'b0;
    zombie_led_d = zombie_led_q;
    score_d      = score_q;
    lives_d      = lives_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    game_over_d  = game_over_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          state_d      = StReq;
          gen_random_d = 1'b1;
          score_d      = '0;
          lives_d      = LivesInit;
          game_over_d  = 1'b0;
        end
      end

      StReq: begin
        state_d = StWait;
      end

      StWait: begin
        if (rand_num == HOLE_NONE) begin
          // Random stage produced no hole; ask again.
          state_d      = StReq;
          gen_random_d = 1'b1;
        end else begin
          hole_d       = rand_num;
          zombie_led_d = hole_onehot(rand_num);
          timer_d      = ShowLoad;
          state_d      = StShow;
        end
      end

      StShow: begin
        // Punches are checked before the timeout so a last-cycle punch counts.
        if (punch_bad || punch_ok || (timer_q == '0)) begin
          zombie_led_d = 3'b000;
          timer_d      = GapLoad;
          state_d      = StGap;
          if (punch_ok && !punch_bad) begin
            hit_d = 1'b1;
            if (score_q != '1) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else begin
            // Wrong button wins over a simultaneous correct one.
            miss_d  = 1'b1;
            lives_d = lives_dec;
            if (lives_dec == 3'd0) begin
              state_d     = StOver;
              game_over_d = 1'b1;
              timer_d     = '0;
            end
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      StGap: begin
        if (timer_q == '0) begin
          state_d      = StReq;
          gen_random_d = 1'b1;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      hole_q       <= HOLE_NONE;
      gen_random_q <= 1'b0;
      zombie_led_q <= 3'b000;
      score_q      <= '0;
      lives_q      <= LivesInit;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hole_q       <= hole_d;
      gen_random_q <= gen_random_d;
      zombie_led_q <= zombie_led_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      game_over_q  <= game_over_d;
    end
  end

  assign gen_random = gen_random_q;
  assign zombie_led = zombie_led_q;
  assign score      = score_q;
  assign lives_left = lives_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_zombie_round_ctrl.sv
// Bench for zombie_round_ctrl: directed rounds, a timestamp-based game model
// compared every cycle, and literal expectations at key points.
module tb_zombie_round_ctrl;

  localparam int unsigned SHOW  = 20;
  localparam int unsigned GAP   = 5;
  localparam int unsigned LIVES = 3;
  localparam int unsigned SW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    btn = 3'b000;
  logic [1:0]    rand_num = 2'd0;
  logic          gen_random;
  logic [2:0]    zombie_led;
  logic [SW-1:0] score;
  logic [2:0]    lives_left;
  logic          hit_pulse;
  logic          miss_pulse;
  logic          game_over;

  always #5 clk = ~clk;

  zombie_round_ctrl #(
    .SHOW_CYCLES (SHOW),
    .GAP_CYCLES  (GAP),
    .LIVES       (LIVES),
    .SCORE_W     (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .btn        (btn),
    .rand_num   (rand_num),
    .gen_random (gen_random),
    .zombie_led (zombie_led),
    .score      (score),
    .lives_left (lives_left),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .game_over  (game_over)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Random stage: answers each request with the next queued hole (default 1).
  logic [1:0] rand_q[$];
  initial begin
    forever begin
      @(posedge clk);
      if (gen_random === 1'b1) begin
        #1;
        if (rand_q.size() > 0) rand_num = rand_q.pop_front();
        else rand_num = 2'd1;
      end
    end
  end

  // Game model: tracks absolute edge numbers of sampling, deadline and resume.
  int         now = 0;
  int         sample_edge = -1;
  int         deadline = -1;
  int         resume_edge = -1;
  bit         running = 1'b0;
  bit         showing = 1'b0;
  logic [2:0] prev_btn = 3'b000;
  logic       prev_start = 1'b0;
  bit         e_gen = 1'b0;
  bit         e_hit = 1'b0;
  bit         e_miss = 1'b0;
  bit         e_over = 1'b0;
  logic [2:0] e_led = 3'b000;
  int         e_score = 0;
  int         e_lives = LIVES;

  initial begin
    forever begin
      logic [2:0] rise;
      logic       srise;
      bit         wrong;
      bit         right;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        now = 0; sample_edge = -1; deadline = -1; resume_edge = -1;
        running = 1'b0; showing = 1'b0; prev_btn = 3'b000; prev_start = 1'b0;
        e_gen = 1'b0; e_hit = 1'b0; e_miss = 1'b0; e_over = 1'b0;
        e_led = 3'b000; e_score = 0; e_lives = LIVES;
      end else begin
        now++;
        rise = btn & ~prev_btn;
        srise = start & ~prev_start;
        prev_btn = btn;
        prev_start = start;
        e_gen = 1'b0; e_hit = 1'b0; e_miss = 1'b0;
        if (!running) begin
          if (srise) begin
            running = 1'b1; e_over = 1'b0; e_score = 0; e_lives = LIVES;
            e_gen = 1'b1; sample_edge = now + 2;
          end
        end else if (now == sample_edge) begin
          if (rand_num == 2'd0) begin
            e_gen = 1'b1; sample_edge = now + 2;
          end else begin
            e_led = 3'b001 << (rand_num - 2'd1);
            showing = 1'b1;
            deadline = now + SHOW;
          end
        end else if (showing) begin
          wrong = |(rise & ~e_led);
          right = |(rise & e_led);
          if (wrong || right || now == deadline) begin
            showing = 1'b0;
            e_led = 3'b000;
            if (wrong || !right) begin
              e_miss = 1'b1; e_lives = e_lives - 1;
            end else begin
              e_hit = 1'b1;
              if (e_score < (1 << SW) - 1) e_score = e_score + 1;
            end
            if (e_lives == 0) begin
              running = 1'b0; e_over = 1'b1;
            end else begin
              resume_edge = now + GAP;
            end
          end
        end else if (now == resume_edge) begin
          e_gen = 1'b1; sample_edge = now + 2;
        end
      end
    end
  end

  task automatic compare_model();
    check("model_gen_random", gen_random, e_gen);
    check("model_zombie_led", zombie_led, e_led);
    check("model_score", score, e_score);
    check("model_lives_left", lives_left, e_lives);
    check("model_hit_pulse", hit_pulse, e_hit);
    check("model_miss_pulse", miss_pulse, e_miss);
    check("model_game_over", game_over, e_over);
  endtask

  // Advance n cycles, comparing against the model mid-cycle; return at posedge+2.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare_model();
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_gen(input string name);
    int k;
    k = 0;
    while (gen_random !== 1'b1 && k < 50) begin
      step(1);
      k++;
    end
    check(name, gen_random, 1);
  endtask

  task automatic do_hit(input logic [1:0] hole, input int delay, input string name);
    logic [2:0] mask;
    mask = 3'b001 << (hole - 2'd1);
    rand_q.push_back(hole);
    wait_gen({name, "_gen"});
    step(2);
    check({name, "_led"}, zombie_led, mask);
    step(delay);
    btn = mask;
    step(1);
    check({name, "_hit"}, hit_pulse, 1);
    btn = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(3);
    check("rst_score", score, 0);
    check("rst_lives", lives_left, 3);
    check("rst_game_over", game_over, 0);
    check("rst_led", zombie_led, 0);
    check("rst_gen", gen_random, 0);
    rst_n = 1'b1;
    step(2);

    // Start, hole 2, hit.
    rand_q.push_back(2'd2);
    start = 1'b1;
    step(1);
    check("t1_gen_pulse", gen_random, 1);
    step(1);
    check("t1_gen_one_cycle", gen_random, 0);
    check("t1_led_in_wait", zombie_led, 0);
    step(1);
    check("t1_led_hole2", zombie_led, 3'b010);
    btn = 3'b010;
    step(1);
    check("t1_hit", hit_pulse, 1);
    check("t1_miss", miss_pulse, 0);
    check("t1_score", score, 1);
    check("t1_led_off", zombie_led, 0);
    btn = 3'b000;
    step(4);
    check("t1_gap_no_gen", gen_random, 0);
    step(1);
    check("t1_gen_after_gap", gen_random, 1);

    // Hole 0 retry, then hole 3; start edge mid-round ignored; wrong+right tie.
    rand_q.push_back(2'd0);
    rand_q.push_back(2'd3);
    start = 1'b0;
    step(1);
    check("t2_gen_low", gen_random, 0);
    step(1);
    check("t2_retry_gen", gen_random, 1);
    step(2);
    check("t2_led_hole3", zombie_led, 3'b100);
    start = 1'b1;
    step(2);
    btn = 3'b101;
    step(1);
    check("t2_tie_miss", miss_pulse, 1);
    check("t2_tie_no_hit", hit_pulse, 0);
    check("t2_score_kept", score, 1);
    check("t2_lives", lives_left, 2);
    btn = 3'b000;

    // Button held from the gap through the window: timeout, then gap presses ignored.
    rand_q.push_back(2'd1);
    btn = 3'b001;
    step(1);
    check("t5_gap_press_hit", hit_pulse, 0);
    check("t5_gap_press_miss", miss_pulse, 0);
    wait_gen("t5_gen");
    step(2);
    check("t5_led_hole1", zombie_led, 3'b001);
    step(19);
    check("t5_no_early_miss", miss_pulse, 0);
    check("t5_led_still_on", zombie_led, 3'b001);
    step(1);
    check("t5_timeout_miss", miss_pulse, 1);
    check("t5_held_no_hit", hit_pulse, 0);
    check("t5_lives", lives_left, 1);
    btn = 3'b000;
    step(1);
    btn = 3'b001;
    step(1);
    check("t5_gap_press2_hit", hit_pulse, 0);
    check("t5_gap_press2_miss", miss_pulse, 0);
    btn = 3'b000;

    // Last life times out: game over.
    rand_q.push_back(2'd2);
    start = 1'b0;
    wait_gen("t3_gen");
    step(2);
    check("t3_led_hole2", zombie_led, 3'b010);
    step(20);
    check("t3_miss", miss_pulse, 1);
    check("t3_lives_zero", lives_left, 0);
    check("t3_game_over", game_over, 1);
    check("t3_led_off", zombie_led, 0);
    step(8);
    check("t3_no_gen_in_over", gen_random, 0);
    check("t3_over_held", game_over, 1);

    // Restart from game over, then four hits (one on the final window cycle).
    start = 1'b1;
    step(1);
    check("t6_gen", gen_random, 1);
    check("t6_score_clr", score, 0);
    check("t6_lives_restored", lives_left, 3);
    check("t6_over_clr", game_over, 0);
    do_hit(2'd2, 0, "h1");
    do_hit(2'd1, 19, "h2_last_cycle");
    do_hit(2'd3, 5, "h3");
    do_hit(2'd2, 3, "h4");
    check("t6_score4", score, 4);

    // Hole 1 with buttons 1 and 2 together: miss only.
    rand_q.push_back(2'd1);
    start = 1'b0;
    wait_gen("t4_gen");
    step(2);
    check("t4_led_hole1", zombie_led, 3'b001);
    btn = 3'b011;
    step(1);
    check("t4_miss", miss_pulse, 1);
    check("t4_no_hit", hit_pulse, 0);
    check("t4_score_kept", score, 4);
    check("t4_lives", lives_left, 2);
    btn = 3'b000;

    // Asynchronous reset in the middle of a window.
    rand_q.push_back(2'd2);
    wait_gen("rst_gen");
    step(5);
    check("rst_pre_led", zombie_led, 3'b010);
    check("rst_pre_score", score, 4);
    #1 rst_n = 1'b0;
    #1;
    check("arst_led", zombie_led, 0);
    check("arst_score", score, 0);
    check("arst_lives", lives_left, 3);
    check("arst_gen", gen_random, 0);
    check("arst_hit", hit_pulse, 0);
    check("arst_miss", miss_pulse, 0);
    check("arst_over", game_over, 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    check("post_rst_idle_gen", gen_random, 0);
    check("post_rst_idle_led", zombie_led, 0);
    start = 1'b1;
    step(1);
    check("post_rst_start_gen", gen_random, 1);
    check("post_rst_score", score, 0);
    check("post_rst_lives", lives_left, 3);
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zombie_round_ctrl.md
Name: zombie_round_ctrl

Overview:
Game-round controller that consumes the 2-bit hole index from the LFSR random stage (values 1..3) and drives the zombie playfield. It requests a number, shows a zombie at that hole, and times the player's punch window. It scores hits and deducts lives on misses or timeouts, and declares game over when lives reach zero. It sits between the random generator and the LED/score display logic.

Parameters:
SHOW_CYCLES, 62_500_000, clk cycles a zombie stays up (punch window)
GAP_CYCLES, 15_625_000, blank cycles between zombies
LIVES, 3, starting lives (1..7)
SCORE_W, 8, score counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge starts a new game from IDLE or OVER
btn  in  3  debounced punch buttons, btn[i] = hole i+1, active-high level
rand_num  in  2  hole index from random stage; valid one cycle after gen_random
gen_random  out  1  one-cycle request pulse to random stage
zombie_led  out  3  one-hot hole display, 0 when no zombie shown
score  out  SCORE_W  hits this game
lives_left  out  3  remaining lives
hit_pulse  out  1  one-cycle pulse on a correct punch
miss_pulse  out  1  one-cycle pulse on a wrong punch or timeout
game_over  out  1  high in OVER state

Behaviour:
- Reset (rst_n low, async): state IDLE; gen_random=0, zombie_led=0, score=0, lives_left=LIVES, hit_pulse=0, miss_pulse=0, game_over=0; timer=0; btn/start edge registers cleared. Reset mid-round aborts immediately with no hit or miss pulse.
- Edge detect: btn and start are registered once; an event is current&~previous. Held buttons never re-trigger.
- States: IDLE, REQ, WAIT, SHOW, GAP, OVER.
- IDLE: on start edge -> REQ. Clear score; set lives_left=LIVES.
- REQ: gen_random=1 for exactly this cycle -> WAIT.
- WAIT: sample rand_num. If rand_num==0, return to REQ (retry, no limit). Otherwise latch hole, set zombie_led=1<<(rand_num-1), load timer=SHOW_CYCLES-1 -> SHOW. Latency from gen_random to LED: 2 cycles.
- SHOW: timer decrements each cycle.
  - Punch edge only on the latched hole: hit_pulse, score+1 (saturates at all-ones).
  - Any punch edge on another hole, including simultaneously with a correct punch: miss_pulse, lives-1. A wrong button wins ties.
  - Timer==0 with no punch: miss_pulse, lives-1.
  - Any of these events: zombie_led=0, timer=GAP_CYCLES-1 -> GAP. If the event makes lives reach 0, go to OVER instead.
  - A punch on the timer==0 cycle counts as the punch, not a timeout.
- GAP: zombie_led=0; button edges are ignored. Timer==0 -> REQ.
- OVER: game_over=1; score and lives_left frozen. Start edge -> REQ with score cleared and lives_left=LIVES.
- Start edges outside IDLE/OVER are ignored.
- Outputs hit_pulse/miss_pulse/gen_random are registered one-cycle pulses; never two in consecutive SHOW exits.
- Timer width: clog2(max(SHOW_CYCLES,GAP_CYCLES)); SHOW_CYCLES, GAP_CYCLES ≥ 2.

Decomposition:
- Shared package: state enum, hole-index constants (HOLE_NONE=0, HOLE_1..3), hole-to-one-hot decode function.
- One sub-module is natural: edge_detect (parameterised width, async active-low reset), instanced for btn (3) and start (1).
- Timer and score stay in the main FSM module.

Test Plan (SHOW_CYCLES=20, GAP_CYCLES=5, LIVES=3; random stage modelled by the bench):
- Reset then start edge, bench drives rand_num=2 after gen_random -> zombie_led=3'b010 exactly 2 cycles after gen_random; press btn[1] -> hit_pulse, score=1, LED off, gen_random again 5 cycles later.
- rand_num=0 in WAIT -> gen_random re-pulses next-next cycle; then rand_num=3 -> zombie_led=3'b100.
- No press for 20 cycles in SHOW -> miss_pulse on cycle 20, lives_left=2; repeat twice -> lives_left=0, game_over=1, zombie_led=0.
- Zombie at hole 1, btn=3'b011 same cycle -> miss_pulse only, score unchanged, lives_left decremented.
- btn[0] held high from before SHOW through the window -> no hit; timeout miss; a press in GAP is ignored.
- Assert rst_n low mid-SHOW with score=4 -> all outputs at reset values asynchronously; start edge in OVER restores score=0, lives_left=3.
